// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   lsu_state_t : controller state encoding (IDLE, ACCESS, RESP)
//   SIZE_BYTE / SIZE_WORD : memory size encoding carried on req_size / mem_size
//   RDATA_ZERO  : response data returned for stores and faulted requests
//   size_span() : offset from first to last byte touched by an access
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    localparam logic [31:0] RDATA_ZERO = 32'h0000_0000;

    function automatic logic [1:0] size_span(input logic size);
        return (size == SIZE_WORD) ? 2'd3 : 2'd0;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: formats raw memory read data into a load result.
//   raw      : data returned by the memory (only [7:0] meaningful for bytes)
//   size     : SIZE_BYTE or SIZE_WORD
//   sign_ext : byte loads only, 1 = replicate bit 7 into [31:8]
//   data     : formatted result
// Purely combinational so it can also sit on the I-cache fill path.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] raw,
    input  logic        size,
    input  logic        sign_ext,
    output logic [31:0] data
);

    always_comb begin
        data = raw;
        if (size == SIZE_BYTE) begin
            data = {{24{sign_ext & raw[7]}}, raw[7:0]};
        end
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store initiator in front of the byte-addressed data memory.
// Takes one request at a time over req_valid/req_ready, range-checks it,
// issues a single-cycle mem_rd or mem_wr strobe, and returns the formatted
// load data (or a fault) over resp_valid/resp_ready.
//
// Ports:
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   req_*             : request handshake and payload (we, size, signed, addr, wdata)
//   resp_*            : response handshake, load data and fault flag
//   mem_*             : data memory port; mem_read_data is combinational
//
// Build option: LSU_MISALIGN_TRAP_EN -- when defined, word requests whose
// address is not 4-byte aligned fault instead of being issued.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// ACCESS | one cycle with mem_rd or mem_wr asserted, load data captured
// RESP   | resp_valid high, held until resp_ready
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    output logic              mem_size,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [31:0]       mem_read_data
);

    localparam logic [ADDR_W:0] LAST_BYTE = (ADDR_W+1)'(MEM_BYTES - 1);

    lsu_state_t state;

    logic              lat_we;
    logic              lat_size;
    logic              lat_signed;
    logic [ADDR_W:0]   end_addr;
    logic              range_fault;
    logic              misalign_fault;
    logic              req_fault;
    logic [31:0]       load_data;

    // One extra bit on the end address turns an address-space wrap into an
    // ordinary out-of-range compare.
    assign end_addr    = {1'b0, req_addr} + (ADDR_W+1)'(size_span(req_size));
    assign range_fault = (end_addr > LAST_BYTE);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_fault = (req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00);
`else
    assign misalign_fault = 1'b0;
`endif

    assign req_fault = range_fault | misalign_fault;

    assign req_ready = (state == IDLE);

    lsu_load_align u_align (
        .raw      (mem_read_data),
        .size     (lat_size),
        .sign_ext (lat_signed),
        .data     (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            lat_we         <= 1'b0;
            lat_size       <= SIZE_BYTE;
            lat_signed     <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= 32'h0;
            mem_size       <= SIZE_BYTE;
            mem_rd         <= 1'b0;
            mem_wr         <= 1'b0;
            resp_valid     <= 1'b0;
            resp_rdata     <= RDATA_ZERO;
            resp_fault     <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses: only the IDLE accept path raises them.
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we     <= req_we;
                        lat_size   <= req_size;
                        lat_signed <= req_signed;
                        if (req_fault) begin
                            resp_rdata <= RDATA_ZERO;
                            resp_fault <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            // Memory-side registers only change on a real access
                            // so they hold their last values in between.
                            mem_address    <= req_addr;
                            mem_write_data <= req_wdata;
                            mem_size       <= req_size;
                            mem_rd         <= ~req_we;
                            mem_wr         <= req_we;
                            state          <= ACCESS;
                        end
                    end
                end

                ACCESS: begin
                    resp_rdata <= lat_we ? RDATA_ZERO : load_data;
                    resp_fault <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end

                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= RDATA_ZERO;
                        resp_fault <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Testbench for lsu_mem_ctrl: directed vector table, hand-written backpressure
// and reset sequences, then random traffic checked against a byte-array model.
module tb_lsu_mem_ctrl;

    localparam int MEM_BYTES = 1024;
    localparam int ADDR_W    = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_fault;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_write_data;
    logic              mem_size;
    logic              mem_rd;
    logic              mem_wr;
    logic [31:0]       mem_read_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_fault     (resp_fault),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_size       (mem_size),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .mem_read_data  (mem_read_data)
    );

    // ---------------- data memory model (environment) ----------------
    logic [7:0]  mem [0:MEM_BYTES-1];
    logic [23:0] junk = 24'h0;
    logic [7:0]  rd_b0, rd_b1, rd_b2, rd_b3;

    always @(negedge clk) junk <= 24'($urandom);

    always_comb begin
        rd_b0 = (mem_address < 32'd1024) ? mem[mem_address[9:0]]          : 8'h00;
        rd_b1 = (mem_address < 32'd1023) ? mem[mem_address[9:0] + 10'd1] : 8'h00;
        rd_b2 = (mem_address < 32'd1022) ? mem[mem_address[9:0] + 10'd2] : 8'h00;
        rd_b3 = (mem_address < 32'd1021) ? mem[mem_address[9:0] + 10'd3] : 8'h00;
        // Byte reads carry garbage above bit 7 so the formatting is exercised.
        mem_read_data = mem_size ? {rd_b3, rd_b2, rd_b1, rd_b0} : {junk, rd_b0};
    end

    always @(posedge clk) begin
        if (mem_wr) begin
            if (mem_address < 32'd1024) mem[mem_address[9:0]] <= mem_write_data[7:0];
            if (mem_size) begin
                if (mem_address < 32'd1023) mem[mem_address[9:0] + 10'd1] <= mem_write_data[15:8];
                if (mem_address < 32'd1022) mem[mem_address[9:0] + 10'd2] <= mem_write_data[23:16];
                if (mem_address < 32'd1021) mem[mem_address[9:0] + 10'd3] <= mem_write_data[31:24];
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [0:MEM_BYTES-1];

    function automatic bit model_fault(input logic [31:0] a, input logic sz);
        longint last;
        bit     f;
        last = longint'(a) + (sz ? 3 : 0);
        f    = (last > MEM_BYTES - 1);
`ifdef LSU_MISALIGN_TRAP_EN
        if (sz && (a % 4 != 0)) f = 1'b1;
`endif
        return f;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic sz, input logic sgn);
        int         i;
        logic [7:0] b;
        i = int'(a);
        if (sz) return {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]};
        b = ref_mem[i];
        if (sgn && b[7]) return 32'hFFFF_FF00 | {24'h0, b};
        return {24'h0, b};
    endfunction

    task automatic model_store(input logic [31:0] a, input logic sz, input logic [31:0] d);
        int i;
        i = int'(a);
        ref_mem[i] = d[7:0];
        if (sz) begin
            ref_mem[i+1] = d[15:8];
            ref_mem[i+2] = d[23:16];
            ref_mem[i+3] = d[31:24];
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Runs one request from IDLE through the response handshake. Latency is
    // the number of edges from the accept edge until resp_valid is seen.
    task automatic run_txn(input logic we, input logic sz, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int bp, input string name,
                           output logic [31:0] rdata, output logic fault,
                           output int lat, output int nrd, output int nwr);
        int guard;
        nrd = 0;
        nwr = 0;
        @(negedge clk);
        req_we     = we;
        req_size   = sz;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        resp_ready = 1'b0;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            nrd += int'(mem_rd);
            nwr += int'(mem_wr);
            @(posedge clk);
            #1;
            lat++;
        end
        if (!resp_valid) chk({name, " resp timeout"}, 32'(resp_valid), 32'd1);
        rdata = resp_rdata;
        fault = resp_fault;
        for (int i = 0; i < bp; i++) begin
            nrd += int'(mem_rd);
            nwr += int'(mem_wr);
            @(posedge clk);
            #1;
            chk({name, " hold valid"}, 32'(resp_valid), 32'd1);
            chk({name, " hold rdata"}, resp_rdata, rdata);
            chk({name, " hold fault"}, 32'(resp_fault), 32'(fault));
            chk({name, " hold req_ready"}, 32'(req_ready), 32'd0);
        end
        nrd += int'(mem_rd);
        nwr += int'(mem_wr);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk({name, " valid drop"}, 32'(resp_valid), 32'd0);
    endtask

    task automatic check_txn(input logic we, input logic sz, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata, input int bp,
                             input logic [31:0] exp_rdata, input logic exp_fault, input string name);
        logic [31:0] rdata;
        logic        fault;
        int          lat, nrd, nwr;
        run_txn(we, sz, sgn, addr, wdata, bp, name, rdata, fault, lat, nrd, nwr);
        chk({name, " rdata"}, rdata, exp_rdata);
        chk({name, " fault"}, 32'(fault), 32'(exp_fault));
        chk({name, " latency"}, 32'(lat), exp_fault ? 32'd1 : 32'd2);
        chk({name, " rd strobes"}, 32'(nrd), (!exp_fault && !we) ? 32'd1 : 32'd0);
        chk({name, " wr strobes"}, 32'(nwr), (!exp_fault && we) ? 32'd1 : 32'd0);
        if (we && !exp_fault) model_store(addr, sz, wdata);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        we;
        logic        sz;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic sz, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_fault);
        vec_t v;
        v.we = we; v.sz = sz; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_fault = exp_fault;
        return v;
    endfunction

    vec_t vecs [16];

    initial begin
        logic [31:0] rdata_bp;
        logic        we, sz, sgn;
        logic [31:0] addr, wdata;
        bit          ok;

        for (int i = 0; i < MEM_BYTES; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end

        vecs[0]  = mk(1, 1, 0, 32'd4,          32'h01000a00, 32'h0,        0);
        vecs[1]  = mk(0, 1, 0, 32'd4,          32'h0,        32'h01000a00, 0);
        vecs[2]  = mk(1, 0, 0, 32'd40,         32'hABCDEF85, 32'h0,        0);
        vecs[3]  = mk(0, 0, 1, 32'd40,         32'h0,        32'hFFFFFF85, 0);
        vecs[4]  = mk(0, 0, 0, 32'd40,         32'h0,        32'h00000085, 0);
        vecs[5]  = mk(1, 1, 0, 32'd16,         32'h11223344, 32'h0,        0);
        vecs[6]  = mk(0, 0, 0, 32'd17,         32'h0,        32'h00000033, 0);
        vecs[7]  = mk(0, 1, 0, 32'd1021,       32'h0,        32'h0,        1);
        vecs[8]  = mk(1, 1, 0, 32'd1020,       32'hCAFEF00D, 32'h0,        0);
        vecs[9]  = mk(0, 1, 0, 32'd1020,       32'h0,        32'hCAFEF00D, 0);
        vecs[10] = mk(1, 1, 0, 32'd1021,       32'h55555555, 32'h0,        1);
        vecs[11] = mk(0, 0, 1, 32'd1023,       32'h0,        32'hFFFFFFCA, 0);
        vecs[12] = mk(0, 0, 0, 32'd1024,       32'h0,        32'h0,        1);
        vecs[13] = mk(0, 1, 0, 32'hFFFFFFFE,   32'h0,        32'h0,        1);
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[14] = mk(0, 1, 0, 32'd6,          32'h0,        32'h0,        1);
`else
        vecs[14] = mk(0, 1, 0, 32'd6,          32'h0,        32'h00000100, 0);
`endif
        vecs[15] = mk(0, 1, 0, 32'd16,         32'h0,        32'h11223344, 0);

        // ---------------- reset state ----------------
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 1'b0;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;
        #2;
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'h0);
        chk("reset resp_fault", 32'(resp_fault), 32'd0);
        chk("reset mem_rd", 32'(mem_rd), 32'd0);
        chk("reset mem_wr", 32'(mem_wr), 32'd0);
        chk("reset mem_address", mem_address, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table ----------------
        for (int i = 0; i < 16; i++) begin
            check_txn(vecs[i].we, vecs[i].sz, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                      i % 4, vecs[i].exp_rdata, vecs[i].exp_fault, $sformatf("vec%0d", i));
        end

        // ---------------- backpressure and no IDLE bypass ----------------
        @(negedge clk);
        req_we = 1'b0; req_size = 1'b1; req_signed = 1'b0; req_addr = 32'd4;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        // Queue the next request immediately; it must wait for the handshake.
        req_size = 1'b0; req_signed = 1'b1; req_addr = 32'd40;
        @(posedge clk);
        #1;
        chk("bp valid", 32'(resp_valid), 32'd1);
        chk("bp rdata", resp_rdata, 32'h01000a00);
        rdata_bp = resp_rdata;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp stall valid", 32'(resp_valid), 32'd1);
            chk("bp stall rdata", resp_rdata, rdata_bp);
            chk("bp stall fault", 32'(resp_fault), 32'd0);
            chk("bp stall req_ready", 32'(req_ready), 32'd0);
            chk("bp stall mem_rd", 32'(mem_rd), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("bp after hs valid", 32'(resp_valid), 32'd0);
        chk("bp after hs req_ready", 32'(req_ready), 32'd1);
        chk("bp no bypass mem_rd", 32'(mem_rd), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("bp next accept mem_rd", 32'(mem_rd), 32'd1);
        chk("bp next addr", mem_address, 32'd40);
        @(posedge clk);
        #1;
        chk("bp next valid", 32'(resp_valid), 32'd1);
        chk("bp next rdata", resp_rdata, 32'hFFFFFF85);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;

        // ---------------- reset during ACCESS of a store ----------------
        @(negedge clk);
        req_we = 1'b1; req_size = 1'b1; req_addr = 32'd100; req_wdata = 32'hDEADBEEF;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("rst pre mem_wr", 32'(mem_wr), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst async mem_wr", 32'(mem_wr), 32'd0);
        chk("rst async mem_rd", 32'(mem_rd), 32'd0);
        chk("rst async req_ready", 32'(req_ready), 32'd1);
        chk("rst async resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ok = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (resp_valid || !req_ready) ok = 1'b0;
        end
        chk("rst dropped request", 32'(ok), 32'd1);
        chk("rst no write", {mem[103], mem[102], mem[101], mem[100]},
            {ref_mem[103], ref_mem[102], ref_mem[101], ref_mem[100]});

        // ---------------- randomized traffic ----------------
        for (int n = 0; n < 150; n++) begin
            int r;
            logic f;
            we    = 1'($urandom_range(0, 1));
            sz    = 1'($urandom_range(0, 1));
            sgn   = 1'($urandom_range(0, 1));
            wdata = $urandom;
            r     = $urandom_range(0, 9);
            if (r == 0)      addr = 32'd1016 + 32'($urandom_range(0, 11));
            else if (r == 1) addr = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
            else             addr = 32'($urandom_range(0, MEM_BYTES - 1));
            f = model_fault(addr, sz);
            check_txn(we, sz, sgn, addr, wdata, $urandom_range(0, 3),
                      (f || we) ? 32'h0 : model_load(addr, sz, sgn), f, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
